// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: glyphs, FSM encoding, digit limits.
package sseg_pkg;

   localparam int unsigned MIN_DIGITS = 2;
   localparam int unsigned MAX_DIGITS = 8;

   // Glyphs are {a,b,c,d,e,f,g,dp}, active-high, dp always clear here
   localparam logic [7:0] SEG_BLANK = 8'h00;
   localparam logic [7:0] SEG_0     = 8'b11111100;
   localparam logic [7:0] SEG_1     = 8'b01100000;
   localparam logic [7:0] SEG_2     = 8'b11011010;
   localparam logic [7:0] SEG_3     = 8'b11110010;
   localparam logic [7:0] SEG_4     = 8'b01100110;
   localparam logic [7:0] SEG_5     = 8'b10110110;
   localparam logic [7:0] SEG_6     = 8'b10111110;
   localparam logic [7:0] SEG_7     = 8'b11100000;
   localparam logic [7:0] SEG_8     = 8'b11111110;
   localparam logic [7:0] SEG_9     = 8'b11110110;
   localparam logic [7:0] SEG_A     = 8'b11101110;
   localparam logic [7:0] SEG_B     = 8'b00111110;
   localparam logic [7:0] SEG_C     = 8'b00011010;
   localparam logic [7:0] SEG_D     = 8'b01111010;
   localparam logic [7:0] SEG_E     = 8'b10011110;
   localparam logic [7:0] SEG_F     = 8'b10001110;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_t;

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to seven-segment glyph (dp bit left clear).
module sseg_hex_decode
   import sseg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] glyph_c
);

   always_comb begin
      glyph_c = SEG_BLANK;
      unique case (nibble)
         4'h0: glyph_c = SEG_0;
         4'h1: glyph_c = SEG_1;
         4'h2: glyph_c = SEG_2;
         4'h3: glyph_c = SEG_3;
         4'h4: glyph_c = SEG_4;
         4'h5: glyph_c = SEG_5;
         4'h6: glyph_c = SEG_6;
         4'h7: glyph_c = SEG_7;
         4'h8: glyph_c = SEG_8;
         4'h9: glyph_c = SEG_9;
         4'hA: glyph_c = SEG_A;
         4'hB: glyph_c = SEG_B;
         4'hC: glyph_c = SEG_C;
         4'hD: glyph_c = SEG_D;
         4'hE: glyph_c = SEG_E;
         4'hF: glyph_c = SEG_F;
         default: glyph_c = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed seven-segment scanner with blanking guard and frame-synchronous value updates.
// Optional leading-zero suppression is enabled by defining SSEG_LZ_BLANK_EN.
module sseg_scan_driver
   import sseg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned SHOW_CYCLES  = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic                    update,
   output logic [7:0]              sseg,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    frame_done
);

   localparam int unsigned MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
   localparam int unsigned VAL_W   = 4 * NUM_DIGITS;

   if (NUM_DIGITS < MIN_DIGITS || NUM_DIGITS > MAX_DIGITS) begin : g_bad_cfg
      $error("sseg_scan_driver: NUM_DIGITS out of range");
   end

   state_t                 state_q, state_n;
   logic [IDX_W-1:0]       idx_q, idx_n;
   logic [CNT_W-1:0]       cnt_q, cnt_n;
   logic [VAL_W-1:0]       act_val_q, act_val_n, pend_val_q, pend_val_n;
   logic [NUM_DIGITS-1:0]  act_dp_q, act_dp_n, pend_dp_q, pend_dp_n;
   logic [NUM_DIGITS-1:0]  act_en_q, act_en_n, pend_en_q, pend_en_n;
   logic                   flag_q, flag_n;
   logic                   boundary_c;
   logic [NUM_DIGITS-1:0]  eff_en_c;
   logic [3:0]             nib_c;
   logic                   en_sel_c, dp_sel_c, show_c;
   logic [7:0]             glyph_c, sseg_n;
   logic [NUM_DIGITS-1:0]  sel_n;

`ifdef SSEG_LZ_BLANK_EN
   // A digit is dark when it and every higher digit hold zero; digit 0 always survives
   logic [NUM_DIGITS-1:0] lz_sup_c;
   always_comb begin
      logic zero_run;
      lz_sup_c = '0;
      zero_run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run    = zero_run & (act_val_q[4*i +: 4] == 4'h0);
         lz_sup_c[i] = zero_run;
      end
   end
   assign eff_en_c = act_en_q & ~lz_sup_c;
`else
   assign eff_en_c = act_en_q;
`endif

   // Slot sequencing and shadow-register handoff
   always_comb begin
      state_n    = state_q;
      idx_n      = idx_q;
      cnt_n      = cnt_q + CNT_W'(1);
      act_val_n  = act_val_q;
      act_dp_n   = act_dp_q;
      act_en_n   = act_en_q;
      pend_val_n = pend_val_q;
      pend_dp_n  = pend_dp_q;
      pend_en_n  = pend_en_q;
      flag_n     = flag_q;
      boundary_c = 1'b0;
      unique case (state_q)
         ST_BLANK: begin
            if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
               state_n = ST_SHOW;
               cnt_n   = '0;
            end
         end
         ST_SHOW: begin
            if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
               state_n = ST_BLANK;
               cnt_n   = '0;
               if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                  idx_n      = '0;
                  boundary_c = 1'b1;
               end else begin
                  idx_n = idx_q + IDX_W'(1);
               end
            end
         end
         default: ;
      endcase
      if (boundary_c) begin
         // Inputs arriving on the boundary edge go straight to the display
         if (update) begin
            act_val_n = value;
            act_dp_n  = dp_in;
            act_en_n  = digit_en;
         end else if (flag_q) begin
            act_val_n = pend_val_q;
            act_dp_n  = pend_dp_q;
            act_en_n  = pend_en_q;
         end
         flag_n = 1'b0;
      end else if (update) begin
         pend_val_n = value;
         pend_dp_n  = dp_in;
         pend_en_n  = digit_en;
         flag_n     = 1'b1;
      end
   end

   // Select the nibble and flags of the digit about to be driven
   always_comb begin
      nib_c    = 4'h0;
      en_sel_c = 1'b0;
      dp_sel_c = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_n == IDX_W'(i)) begin
            nib_c    = act_val_q[4*i +: 4];
            en_sel_c = eff_en_c[i];
            dp_sel_c = act_dp_q[i];
         end
      end
   end

   sseg_hex_decode u_decode (
      .nibble  (nib_c),
      .glyph_c (glyph_c)
   );

   // Next output values, registered together so sel and segments never skew
   always_comb begin
      sel_n  = '1;
      show_c = (state_n == ST_SHOW) && en_sel_c;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (show_c && (idx_n == IDX_W'(i))) sel_n[i] = 1'b0;
      end
      sseg_n = show_c ? (glyph_c | {7'b0, dp_sel_c}) : SEG_BLANK;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_BLANK;
         idx_q      <= '0;
         cnt_q      <= '0;
         act_val_q  <= '0;
         act_dp_q   <= '0;
         act_en_q   <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pend_en_q  <= '0;
         flag_q     <= 1'b0;
         sseg       <= SEG_BLANK;
         digit_sel  <= '1;
         frame_done <= 1'b0;
      end else begin
         state_q    <= state_n;
         idx_q      <= idx_n;
         cnt_q      <= cnt_n;
         act_val_q  <= act_val_n;
         act_dp_q   <= act_dp_n;
         act_en_q   <= act_en_n;
         pend_val_q <= pend_val_n;
         pend_dp_q  <= pend_dp_n;
         pend_en_q  <= pend_en_n;
         flag_q     <= flag_n;
         sseg       <= sseg_n;
         digit_sel  <= sel_n;
         frame_done <= boundary_c;
      end
   end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed self-checking bench for sseg_scan_driver (SHOW=4, BLANK=2, 4 digits, 24-cycle frame).
module tb_sseg_scan_driver;

   logic        clk;
   logic        rst;
   logic [15:0] value;
   logic [3:0]  dp_in;
   logic [3:0]  digit_en;
   logic        update;
   logic [7:0]  sseg;
   logic [3:0]  digit_sel;
   logic        frame_done;

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  exp_g [4];
   logic        exp_on [4];
   logic [12:0] exp_v;

   sseg_scan_driver #(
      .NUM_DIGITS   (4),
      .SHOW_CYCLES  (4),
      .BLANK_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value      (value),
      .dp_in      (dp_in),
      .digit_en   (digit_en),
      .update     (update),
      .sseg       (sseg),
      .digit_sel  (digit_sel),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input logic [7:0] g3, g2, g1, g0, input logic [3:0] on);
      exp_g[3] = g3; exp_g[2] = g2; exp_g[1] = g1; exp_g[0] = g0;
      exp_on[3] = on[3]; exp_on[2] = on[2]; exp_on[1] = on[1]; exp_on[0] = on[0];
   endtask

   // Expected {frame_done, digit_sel, sseg} after edge r (1..24) of a frame
   function automatic logic [12:0] exp_out(input int r);
      logic       fd;
      logic [3:0] sel;
      logic [7:0] seg;
      int         d, j;
      fd  = (r == 24);
      sel = 4'b1111;
      seg = 8'h00;
      d   = r / 6;
      j   = r % 6;
      if (j >= 2 && d < 4 && exp_on[d]) begin
         sel[d] = 1'b0;
         seg    = exp_g[d];
      end
      return {fd, sel, seg};
   endfunction

   task automatic test_reset();
      rst = 1'b0; update = 1'b0; value = '0; dp_in = '0; digit_en = '0;
      repeat (5) tick();
      n_vec++;
      if ({frame_done, digit_sel, sseg} !== 13'b0_1111_00000000) begin
         n_err++;
         $display("FAIL reset_hold got %h want %h", {frame_done, digit_sel, sseg}, 13'b0_1111_00000000);
      end
      rst = 1'b1;
      set_exp(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
      for (int r = 1; r <= 24; r++) begin
         tick();
         exp_v = exp_out(r);
         n_vec++;
         if ({frame_done, digit_sel, sseg} !== exp_v) begin
            n_err++;
            $display("FAIL reset_frame r=%0d got %h want %h", r, {frame_done, digit_sel, sseg}, exp_v);
         end
      end
   endtask

   task automatic test_scan();
      value = 16'h3A90; dp_in = 4'b0100; digit_en = 4'hF;
      for (int r = 1; r <= 24; r++) begin
         update = (r == 23);
         tick();
         exp_v = exp_out(r);
         n_vec++;
         if ({frame_done, digit_sel, sseg} !== exp_v) begin
            n_err++;
            $display("FAIL scan_pending r=%0d got %h want %h", r, {frame_done, digit_sel, sseg}, exp_v);
         end
      end
      update = 1'b0;
      set_exp(8'hF2, 8'hEF, 8'hF6, 8'hFC, 4'b1111);
      for (int r = 1; r <= 24; r++) begin
         tick();
         exp_v = exp_out(r);
         n_vec++;
         if ({frame_done, digit_sel, sseg} !== exp_v) begin
            n_err++;
            $display("FAIL scan_show r=%0d got %h want %h", r, {frame_done, digit_sel, sseg}, exp_v);
         end
      end
   endtask

   task automatic test_tear_free();
      dp_in = 4'b0000; digit_en = 4'hF;
      for (int r = 1; r <= 24; r++) begin
         update = (r == 6) || (r == 8);
         value  = (r == 6) ? 16'h2222 : 16'h1111;
         tick();
         exp_v = exp_out(r);
         n_vec++;
         if ({frame_done, digit_sel, sseg} !== exp_v) begin
            n_err++;
            $display("FAIL tear_hold r=%0d got %h want %h", r, {frame_done, digit_sel, sseg}, exp_v);
         end
      end
      update = 1'b0;
      set_exp(8'h60, 8'h60, 8'h60, 8'h60, 4'b1111);
      for (int r = 1; r <= 24; r++) begin
         tick();
         exp_v = exp_out(r);
         n_vec++;
         if ({frame_done, digit_sel, sseg} !== exp_v) begin
            n_err++;
            $display("FAIL tear_new r=%0d got %h want %h", r, {frame_done, digit_sel, sseg}, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      // Still 1111 this frame; load C7B2 on the boundary edge itself
      value = 16'hC7B2; dp_in = 4'b0001; digit_en = 4'b1011;
      for (int r = 1; r <= 24; r++) begin
         update = (r == 24);
         tick();
         exp_v = exp_out(r);
         n_vec++;
         if ({frame_done, digit_sel, sseg} !== exp_v) begin
            n_err++;
            $display("FAIL simul_before r=%0d got %h want %h", r, {frame_done, digit_sel, sseg}, exp_v);
         end
      end
      update = 1'b0;
      set_exp(8'h1A, 8'hE0, 8'h3E, 8'hDB, 4'b1011);
      for (int f = 0; f < 2; f++) begin
         for (int r = 1; r <= 24; r++) begin
            tick();
            exp_v = exp_out(r);
            n_vec++;
            if ({frame_done, digit_sel, sseg} !== exp_v) begin
               n_err++;
               $display("FAIL simul_frame%0d r=%0d got %h want %h", f, r, {frame_done, digit_sel, sseg}, exp_v);
            end
         end
      end
   endtask

   task automatic test_lz();
      value = 16'h0050; dp_in = 4'b0000; digit_en = 4'hF;
      for (int r = 1; r <= 24; r++) begin
         update = (r == 10);
         tick();
         exp_v = exp_out(r);
         n_vec++;
         if ({frame_done, digit_sel, sseg} !== exp_v) begin
            n_err++;
            $display("FAIL lz_prev r=%0d got %h want %h", r, {frame_done, digit_sel, sseg}, exp_v);
         end
      end
`ifdef SSEG_LZ_BLANK_EN
      set_exp(8'h00, 8'h00, 8'hB6, 8'hFC, 4'b0011);
`else
      set_exp(8'hFC, 8'hFC, 8'hB6, 8'hFC, 4'b1111);
`endif
      value = 16'h0000;
      for (int r = 1; r <= 24; r++) begin
         update = (r == 10);
         tick();
         exp_v = exp_out(r);
         n_vec++;
         if ({frame_done, digit_sel, sseg} !== exp_v) begin
            n_err++;
            $display("FAIL lz_0050 r=%0d got %h want %h", r, {frame_done, digit_sel, sseg}, exp_v);
         end
      end
`ifdef SSEG_LZ_BLANK_EN
      set_exp(8'h00, 8'h00, 8'h00, 8'hFC, 4'b0001);
`else
      set_exp(8'hFC, 8'hFC, 8'hFC, 8'hFC, 4'b1111);
`endif
      value = 16'h8888;
      for (int r = 1; r <= 24; r++) begin
         update = (r == 10);
         tick();
         exp_v = exp_out(r);
         n_vec++;
         if ({frame_done, digit_sel, sseg} !== exp_v) begin
            n_err++;
            $display("FAIL lz_0000 r=%0d got %h want %h", r, {frame_done, digit_sel, sseg}, exp_v);
         end
      end
      update = 1'b0;
   endtask

   task automatic test_reset_mid();
      set_exp(8'hFE, 8'hFE, 8'hFE, 8'hFE, 4'b1111);
      for (int r = 1; r <= 15; r++) begin
         tick();
         exp_v = exp_out(r);
         n_vec++;
         if ({frame_done, digit_sel, sseg} !== exp_v) begin
            n_err++;
            $display("FAIL mid_pre r=%0d got %h want %h", r, {frame_done, digit_sel, sseg}, exp_v);
         end
      end
      rst = 1'b0;
      tick();
      n_vec++;
      if ({frame_done, digit_sel, sseg} !== 13'b0_1111_00000000) begin
         n_err++;
         $display("FAIL mid_reset got %h want %h", {frame_done, digit_sel, sseg}, 13'b0_1111_00000000);
      end
      rst = 1'b1;
      // Active regs cleared: a full dark frame with the boundary pulse on schedule
      set_exp(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
      for (int r = 1; r <= 24; r++) begin
         tick();
         exp_v = exp_out(r);
         n_vec++;
         if ({frame_done, digit_sel, sseg} !== exp_v) begin
            n_err++;
            $display("FAIL mid_after r=%0d got %h want %h", r, {frame_done, digit_sel, sseg}, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_tear_free();
      test_back_to_back();
      test_lz();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
